// File: rtl/led_flow_ctrl.sv
// Running-light engine: a free-running step prescaler drives LED_NUM outputs
// through rotate-left, rotate-right, ping-pong or hold modes. A pattern can be
// loaded at runtime, and the en input freezes both the prescaler and the
// pattern. Every output is registered.
module led_flow_ctrl #(
  parameter int LED_NUM     = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int STEP_HZ     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [LED_NUM-1:0] load_pattern,
  output logic [LED_NUM-1:0] led,
  output logic               dir,
  output logic               step_tick
);

  localparam int DIV   = CLK_FREQ_HZ / STEP_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_ROT_L = 2'b00,
    MODE_ROT_R = 2'b01,
    MODE_PING  = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  logic [CNT_W-1:0]   cnt;
  logic [LED_NUM-1:0] led_next;
  logic               dir_next;
  logic               step;
  logic [LED_NUM-1:0] load_value;

  assign step       = en && (cnt == CNT_LAST);
  // An all-dark pattern would stay dark forever, so it is replaced by bit 0.
  assign load_value = (load_pattern == '0) ? LED_NUM'(1) : load_pattern;

  // Pattern and direction that the next step would produce in the current mode.
  // NOTE: every signal gets a default at the top of always_comb so no path can leave it unassigned and infer a latch.
  always_comb begin
    led_next = led;
    dir_next = dir;
    case (mode_e'(mode))
      MODE_ROT_L: led_next = {led[LED_NUM-2:0], led[LED_NUM-1]};
      MODE_ROT_R: led_next = {led[0], led[LED_NUM-1:1]};
      MODE_PING: begin
        if (!dir) begin
          if (led[LED_NUM-1]) begin
            dir_next = 1'b1;
            led_next = led >> 1;
          end else begin
            led_next = led << 1;
          end
        end else begin
          if (led[0]) begin
            dir_next = 1'b0;
            led_next = led << 1;
          end else begin
            led_next = led >> 1;
          end
        end
      end
      default: ;  // hold: pattern and direction stay put
    endcase
  end

  // Prescaler, pattern register and step pulse; reset beats load, load beats a step.
  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      led       <= LED_NUM'(1);
      dir       <= 1'b0;
      step_tick <= 1'b0;
    end else if (load) begin
      cnt       <= '0;
      led       <= load_value;
      dir       <= 1'b0;
      step_tick <= 1'b0;
    end else if (step) begin
      cnt       <= '0;
      led       <= led_next;
      dir       <= dir_next;
      step_tick <= 1'b1;
    end else begin
      if (en) cnt <= cnt + CNT_W'(1);
      step_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Self-checking bench for led_flow_ctrl (LED_NUM=4, DIV=8). Directed scenes
// followed by randomized stimulus, all checked against a cycle model that
// counts enabled cycles toward DIV and steps the pattern with integer maths.
module tb_led_flow_ctrl;

  localparam int N    = 4;
  localparam int CLKF = 8;
  localparam int STEP = 1;
  localparam int DIV  = CLKF / STEP;
  localparam int FULL = 1 << N;

  logic         clk = 1'b0;
  logic         rst, en, load;
  logic [1:0]   mode;
  logic [N-1:0] load_pattern;
  logic [N-1:0] led;
  logic         dir, step_tick;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state
  int m_led, m_dir, m_tick, m_elapsed;

  led_flow_ctrl #(.LED_NUM(N), .CLK_FREQ_HZ(CLKF), .STEP_HZ(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_pattern(load_pattern), .led(led), .dir(dir), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      m_led = 1; m_dir = 0; m_tick = 0; m_elapsed = 0;
    end else if (load) begin
      m_led = (load_pattern == 0) ? 1 : int'(load_pattern);
      m_dir = 0; m_tick = 0; m_elapsed = 0;
    end else if (en) begin
      m_elapsed++;
      m_tick = 0;
      if (m_elapsed == DIV) begin
        m_elapsed = 0;
        m_tick = 1;
        case (mode)
          2'b00: m_led = (m_led * 2) % FULL + m_led / (FULL / 2);
          2'b01: m_led = m_led / 2 + (m_led % 2) * (FULL / 2);
          2'b10: begin
            if (m_dir == 0) begin
              if (m_led >= FULL / 2) begin m_dir = 1; m_led = m_led / 2; end
              else m_led = (m_led * 2) % FULL;
            end else begin
              if (m_led % 2 == 1) begin m_dir = 0; m_led = (m_led * 2) % FULL; end
              else m_led = m_led / 2;
            end
          end
          default: ;
        endcase
      end
    end else begin
      m_tick = 0;
    end
  endtask

  // One clock: update model, let the edge happen, sample 1 ns later and compare.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("led", int'(led), m_led);
    check("dir", int'(dir), m_dir);
    check("step_tick", int'(step_tick), m_tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; mode = 2'b00; load_pattern = '0;
    m_led = 0; m_dir = 0; m_tick = 0; m_elapsed = 0;

    // 1: reset then rotate-left
    cycle();
    check("reset_led", int'(led), 1);
    check("reset_tick", int'(step_tick), 0);
    rst = 1'b0;
    run(7);
    check("rotl_before_step", int'(led), 1);
    cycle();
    check("rotl_first_step", int'(led), 2);
    check("rotl_first_tick", int'(step_tick), 1);
    run(32);

    // 2: ping-pong from 0001
    load = 1'b1; load_pattern = 4'b0001; cycle(); load = 1'b0;
    mode = 2'b10;
    run(8 * DIV);

    // 3: freeze mid-period at cnt=5
    run(5);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(2);
    check("freeze_no_early_tick", int'(step_tick), 0);
    cycle();
    check("freeze_resume_tick", int'(step_tick), 1);

    // 4: load 0110 in rotate-right
    mode = 2'b01; load = 1'b1; load_pattern = 4'b0110; cycle(); load = 1'b0;
    check("load_0110", int'(led), 6);
    run(DIV);
    check("rotr_0011", int'(led), 3);
    run(DIV);
    check("rotr_1001", int'(led), 9);

    // 5: load of 0000 landing on a step edge
    for (int i = 0; i < 2 * DIV && m_elapsed != DIV - 1; i++) cycle();
    load = 1'b1; load_pattern = 4'b0000; cycle(); load = 1'b0;
    check("load_zero_led", int'(led), 1);
    check("load_zero_tick", int'(step_tick), 0);
    run(DIV - 1);
    check("load_zero_no_tick", int'(step_tick), 0);
    cycle();
    check("load_zero_cnt_restart", int'(step_tick), 1);

    // 6: reset with load mid-ping-pong at led=0100, dir=1
    mode = 2'b10;
    begin
      int budget = 20 * DIV;
      while (!(m_led == 4 && m_dir == 1) && budget > 0) begin cycle(); budget--; end
      check("pingpong_reach_budget", (budget > 0) ? 1 : 0, 1);
    end
    rst = 1'b1; load = 1'b1; load_pattern = 4'b1111; cycle();
    rst = 1'b0; load = 1'b0;
    check("rst_over_load_led", int'(led), 1);
    check("rst_over_load_dir", int'(dir), 0);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      load         = ($urandom_range(0, 39) == 0);
      en           = ($urandom_range(0, 9) != 0);
      load_pattern = N'($urandom);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
